square_wave_ctrl: RTL and testbench
===================================

Name: square_wave_ctrl

Overview:
- Sequencer for the 1024-entry square-wave LUT generator.
- Owns the phase accumulator and the duty-cycle select that feed the generator's address and duty inputs.
- Accepts frequency, duty and burst-length configuration through a valid/ready handshake and applies it glitch-free only at a waveform period boundary.
- Runs continuously or for a fixed number of periods, with start/stop control.

Parameters:
- ACC_W, 32, phase accumulator width.
- ADDR_W, 10, LUT address width; top ADDR_W bits of the accumulator.
- CNT_W, 16, burst period counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle stop request.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_ftw  in  ACC_W  frequency tuning word.
- cfg_duty  in  4  duty select: 0=10%, 1=25%, 2=50%, 3=75%.
- cfg_cycles  in  CNT_W  burst length in periods; 0 means continuous.
- phase_acc  out  ADDR_W  LUT address, equal to acc[ACC_W-1 -: ADDR_W].
- duty_cycle  out  4  duty select to the generator.
- active  out  1  high while in RUN.
- wrap_tick  out  1  one-cycle pulse on accumulator wrap.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset values:
  - acc=0, so phase_acc=0.
  - duty_cycle=2, ftw=0, cycles=0, remaining=0.
  - Pending slot empty, stop latch clear, state IDLE.
  - cfg_ready=1, active=0, wrap_tick=0, done=0.
  - Reset mid-run takes the same values; any pending config is discarded.
- Duty clamp: cfg_duty values 4..15 are stored as 2. duty_cycle output is always in 0..3.
- Config transfer occurs when cfg_valid && cfg_ready.
  - IDLE: cfg_ready=1. ftw, duty and cycles registers are updated on the transfer edge and visible the next cycle.
  - RUN with no pending config: cfg_ready=1 and the transfer fills the pending slot. cfg_ready=0 while the slot is full.
  - The slot is applied to ftw, duty and cycles on the next wrap edge, then cleared; cfg_ready=1 the following cycle.
  - Transfer on the same edge as a wrap: the new config is applied at that wrap and the slot stays empty.
  - Applied ftw takes effect from the first increment after the wrap.
  - Applied cycles does not alter the running remaining count; it is used at the next start.
- States: IDLE and RUN.
- IDLE:
  - acc held at 0, active=0.
  - start: go to RUN, acc=0, remaining=cycles. start has priority over a same-cycle stop, which is discarded.
  - stop alone is ignored.
- RUN:
  - active=1; acc <= acc + ftw modulo 2^ACC_W every cycle, beginning the cycle after entry.
  - wrap is the carry-out of the addition. wrap_tick is registered and high in the cycle acc holds the wrapped value.
  - start is ignored.
  - stop sets the stop latch.
  - At a wrap with the stop latch set, or with cycles!=0 and remaining==1: go to IDLE, acc=0, done=1 for one cycle, latch cleared.
  - Otherwise, if cycles!=0, decrement remaining at each wrap.
  - A pending config is still applied at a terminating wrap.
- ftw==0 in RUN never wraps, so stop forces IDLE on the next edge with done=1 and no wrap_tick.
- A stop arriving on the same edge as a wrap counts as latched after that wrap and terminates at the following wrap.
- Latency:
  - start to first phase_acc=0 with active=1 is 1 cycle.
  - Address sequence thereafter is 0, ftw>>22, and so on (for defaults).

Test Plan:
- Reset, set ftw=2^30, duty=1, cycles=0 in IDLE, then start -> active=1 next cycle; phase_acc repeats 0,256,512,768,0 with wrap_tick on each 0 after the first; duty_cycle=1.
- cycles=3, ftw=2^30, start -> exactly 3 wrap_tick pulses are generated, the first two over 4 cycles each; the third wrap coincides with IDLE: done=1 for one cycle, active=0, phase_acc=0.
- Running ftw=2^30, offer ftw=2^29, duty=3 mid-period -> cfg_ready drops for the rest of the period; new config takes effect at the next wrap: step 128, duty_cycle=3; cfg_ready=1 the cycle after.
- Running, pulse stop 1 cycle after a wrap -> acc continues to the next wrap, then done=1 and IDLE. A second stop pulse while IDLE produces no effect.
- ftw=0, start, stop -> IDLE on the next edge with done=1 and wrap_tick never asserted. cfg_duty=9 in IDLE -> duty_cycle=2.
- Continuous run, assert rst for one cycle mid-period with a config pending -> all outputs at reset values; cfg_ready=1; the old pending config is never applied after a subsequent start.

Source files
------------

// File: rtl/square_wave_ctrl.sv
// rtl/square_wave_ctrl.sv - phase accumulator and duty sequencer for the square-wave LUT generator
// Config is staged in a one-deep slot while running and committed only at a period wrap.
module square_wave_ctrl #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [3:0]        cfg_duty,
  input  logic [CNT_W-1:0]  cfg_cycles,
  output logic [ADDR_W-1:0] phase_acc,
  output logic [3:0]        duty_cycle,
  output logic              active,
  output logic              wrap_tick,
  output logic              done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_ftw;
  logic [1:0]       r_duty;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_remaining;
  logic             r_pend_valid;
  logic [ACC_W-1:0] r_pend_ftw;
  logic [1:0]       r_pend_duty;
  logic [CNT_W-1:0] r_pend_cycles;
  logic             r_stop_latch;
  logic             r_wrap_tick;
  logic             r_done;

  logic             w_xfer;
  logic             w_carry;
  logic [ACC_W-1:0] w_sum;
  logic             w_wrap;
  logic             w_fstop;
  logic             w_cnt_end;
  logic             w_end;
  logic             w_apply;
  logic [1:0]       w_cfg_duty;

  assign cfg_ready  = !r_pend_valid;
  assign w_xfer     = cfg_valid && cfg_ready;
  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_ftw};
  assign w_wrap     = (r_state == S_RUN) && w_carry;
  // A zero tuning word never wraps, so a stop has to end the run without waiting for one.
  assign w_fstop    = (r_state == S_RUN) && (r_ftw == '0) && (stop || r_stop_latch);
  assign w_cnt_end  = (r_cycles != '0) && (r_remaining == CNT_W'(1));
  assign w_end      = w_fstop || (w_wrap && (r_stop_latch || w_cnt_end));
  assign w_apply    = w_wrap || w_fstop;
  assign w_cfg_duty = (cfg_duty > 4'd3) ? 2'd2 : cfg_duty[1:0];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_ftw         <= '0;
      r_duty        <= 2'd2;
      r_cycles      <= '0;
      r_remaining   <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_ftw    <= '0;
      r_pend_duty   <= 2'd2;
      r_pend_cycles <= '0;
      r_stop_latch  <= 1'b0;
      r_wrap_tick   <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wrap_tick <= w_wrap;
      r_done      <= w_end;
      if (r_state == S_IDLE) begin
        r_acc        <= '0;
        r_stop_latch <= 1'b0;
        if (w_xfer) begin
          r_ftw    <= cfg_ftw;
          r_duty   <= w_cfg_duty;
          r_cycles <= cfg_cycles;
        end
        if (start) r_remaining <= w_xfer ? cfg_cycles : r_cycles;
      end else begin
        if (w_apply) begin
          if (w_xfer) begin
            r_ftw    <= cfg_ftw;
            r_duty   <= w_cfg_duty;
            r_cycles <= cfg_cycles;
          end else if (r_pend_valid) begin
            r_ftw    <= r_pend_ftw;
            r_duty   <= r_pend_duty;
            r_cycles <= r_pend_cycles;
          end
          r_pend_valid <= 1'b0;
        end else if (w_xfer) begin
          r_pend_valid  <= 1'b1;
          r_pend_ftw    <= cfg_ftw;
          r_pend_duty   <= w_cfg_duty;
          r_pend_cycles <= cfg_cycles;
        end
        if (w_end) begin
          r_acc        <= '0;
          r_stop_latch <= 1'b0;
        end else begin
          r_acc <= w_sum;
          // A stop coinciding with a wrap belongs to the next period.
          if (w_wrap) begin
            r_stop_latch <= stop;
            if (r_cycles != '0) r_remaining <= r_remaining - CNT_W'(1);
          end else if (stop) begin
            r_stop_latch <= 1'b1;
          end
        end
      end
    end
  end

  assign phase_acc  = r_acc[ACC_W-1 -: ADDR_W];
  assign duty_cycle = {2'b00, r_duty};
  assign active     = (r_state == S_RUN);
  assign wrap_tick  = r_wrap_tick;
  assign done       = r_done;

endmodule

// File: tb/tb_square_wave_ctrl.sv
// tb/tb_square_wave_ctrl.sv - directed and random checks of square_wave_ctrl against a period-level model
module tb_square_wave_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_ftw = '0;
  logic [3:0]  cfg_duty = '0;
  logic [15:0] cfg_cycles = '0;
  logic [9:0]  phase_acc;
  logic [3:0]  duty_cycle;
  logic        active;
  logic        wrap_tick;
  logic        done;

  int checks = 0;
  int failures = 0;

  square_wave_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ftw(cfg_ftw), .cfg_duty(cfg_duty), .cfg_cycles(cfg_cycles),
    .phase_acc(phase_acc), .duty_cycle(duty_cycle),
    .active(active), .wrap_tick(wrap_tick), .done(done)
  );

  always #5 clk = ~clk;

  localparam longint unsigned MOD = 64'h1_0000_0000;

  // Model state: phase as an unbounded sum reduced mod 2^32, config as plain integers.
  longint unsigned m_acc;
  longint unsigned m_ftw;
  int  m_duty, m_cycles, m_rem;
  bit  m_run, m_pend, m_stopl, e_wrap, e_done;
  longint unsigned p_ftw;
  int  p_duty, p_cycles;

  function automatic int clamp(input int d);
    return (d > 3) ? 2 : d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phase_acc",  {22'd0, phase_acc}, 32'(m_acc >> 22));
    chk("duty_cycle", {28'd0, duty_cycle}, 32'(m_duty));
    chk("active",     {31'd0, active},    {31'd0, m_run});
    chk("wrap_tick",  {31'd0, wrap_tick}, {31'd0, e_wrap});
    chk("done",       {31'd0, done},      {31'd0, e_done});
    chk("cfg_ready",  {31'd0, cfg_ready}, {31'd0, !m_pend});
  endtask

  task automatic model_reset();
    m_acc = 0; m_ftw = 0; m_duty = 2; m_cycles = 0; m_rem = 0;
    m_run = 0; m_pend = 0; m_stopl = 0; e_wrap = 0; e_done = 0;
    p_ftw = 0; p_duty = 2; p_cycles = 0;
  endtask

  task automatic take_cfg(input bit from_pend, input bit s, input bit v);
    if (!from_pend) begin
      m_ftw = longint'(cfg_ftw); m_duty = clamp(int'(cfg_duty)); m_cycles = int'(cfg_cycles);
    end else begin
      m_ftw = p_ftw; m_duty = p_duty; m_cycles = p_cycles;
    end
  endtask

  task automatic model_step(input bit s, input bit p, input bit v);
    bit xfer, ending;
    int old_cycles;
    longint unsigned sum;
    xfer = v && !m_pend;
    e_wrap = 0; e_done = 0;
    if (!m_run) begin
      if (xfer) take_cfg(0, s, v);
      if (s) begin m_run = 1; m_acc = 0; m_rem = m_cycles; m_stopl = 0; end
    end else begin
      sum = m_acc + m_ftw;
      old_cycles = m_cycles;
      if (sum >= MOD || (m_ftw == 0 && (p || m_stopl))) begin
        e_wrap = (sum >= MOD);
        ending = !e_wrap || m_stopl || (old_cycles != 0 && m_rem == 1);
        if (xfer) take_cfg(0, s, v);
        else if (m_pend) take_cfg(1, s, v);
        m_pend = 0;
        if (ending) begin
          m_run = 0; m_acc = 0; e_done = 1; m_stopl = 0;
        end else begin
          m_acc = sum - MOD; m_stopl = p;
          if (old_cycles != 0) m_rem = (m_rem - 1) & 16'hFFFF;
        end
      end else begin
        m_acc = sum;
        if (p) m_stopl = 1;
        if (xfer) begin
          m_pend = 1; p_ftw = longint'(cfg_ftw); p_duty = clamp(int'(cfg_duty)); p_cycles = int'(cfg_cycles);
        end
      end
    end
  endtask

  task automatic cyc(input bit s, input bit p, input bit v, input logic [31:0] f,
                     input logic [3:0] d, input logic [15:0] c);
    start = s; stop = p; cfg_valid = v; cfg_ftw = f; cfg_duty = d; cfg_cycles = c;
    @(posedge clk);
    model_step(s, p, v);
    #1;
    check_all();
    start = 0; stop = 0; cfg_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, cfg_ftw, cfg_duty, cfg_cycles);
  endtask

  task automatic do_reset();
    rst = 1; start = 0; stop = 0; cfg_valid = 0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 0;
    check_all();
  endtask

  initial begin
    model_reset();
    do_reset();

    cyc(0, 0, 1, 32'h4000_0000, 4'd1, 16'd0);
    cyc(1, 0, 0, 32'h4000_0000, 4'd1, 16'd0);
    idle(9);
    cyc(0, 1, 0, cfg_ftw, cfg_duty, cfg_cycles);
    idle(8);

    cyc(0, 0, 1, 32'h4000_0000, 4'd2, 16'd3);
    cyc(1, 0, 0, cfg_ftw, cfg_duty, cfg_cycles);
    idle(14);

    cyc(0, 0, 1, 32'h4000_0000, 4'd1, 16'd0);
    cyc(1, 0, 0, cfg_ftw, cfg_duty, cfg_cycles);
    idle(2);
    cyc(0, 0, 1, 32'h2000_0000, 4'd3, 16'd0);
    idle(12);
    cyc(0, 1, 0, cfg_ftw, cfg_duty, cfg_cycles);
    idle(12);
    cyc(0, 1, 0, cfg_ftw, cfg_duty, cfg_cycles);
    idle(2);

    cyc(0, 0, 1, 32'h0, 4'd1, 16'd0);
    cyc(1, 1, 0, cfg_ftw, cfg_duty, cfg_cycles);
    idle(3);
    cyc(0, 1, 0, cfg_ftw, cfg_duty, cfg_cycles);
    idle(3);
    cyc(0, 0, 1, 32'h0, 4'd9, 16'd0);
    idle(1);

    cyc(0, 0, 1, 32'h4000_0000, 4'd1, 16'd0);
    cyc(1, 0, 0, cfg_ftw, cfg_duty, cfg_cycles);
    idle(1);
    cyc(0, 0, 1, 32'h2000_0000, 4'd0, 16'd0);
    do_reset();
    cyc(0, 0, 1, 32'h4000_0000, 4'd1, 16'd0);
    cyc(1, 0, 0, cfg_ftw, cfg_duty, cfg_cycles);
    idle(10);
    cyc(0, 1, 0, cfg_ftw, cfg_duty, cfg_cycles);
    idle(6);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] f;
      f = ($urandom_range(0, 9) == 0) ? 32'h0 : (($urandom >> $urandom_range(1, 4)) | 32'h0100_0000);
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
          f, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 3)));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
